// File: rtl/i2c_sensor_responder_if.sv
// Bus bundle for i2c_sensor_responder: I2C pin levels, host preload port, write-commit report, FSM debug.
// Handshake: host_we is a one-cycle write strobe and wr_stb a one-cycle valid; neither side has a ready, so
// both are always accepted in the cycle they are asserted. sda_oe=1 means the target pulls SDA low.
interface i2c_sensor_responder_if #(
  parameter int REG_AW = 6
);
  logic              scl_i;
  logic              sda_i;
  logic              sda_oe;
  logic              host_we;
  logic [REG_AW-1:0] host_addr;
  logic [7:0]        host_data;
  logic              wr_stb;
  logic [REG_AW-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              busy;
  logic [3:0]        dbg_state;

  modport slave (
    input  scl_i, sda_i, host_we, host_addr, host_data,
    output sda_oe, wr_stb, wr_addr, wr_data, busy, dbg_state
  );

  modport master (
    output scl_i, sda_i, host_we, host_addr, host_data,
    input  sda_oe, wr_stb, wr_addr, wr_data, busy, dbg_state
  );
endinterface

// File: rtl/i2c_sensor_responder.sv
// I2C target emulating one sensor device with a host-preloadable 8-bit register file.
// Optional macro I2C_RESP_AUTOINC_EN: pointer advances only when sub-address bit 7 was set.
module i2c_sensor_responder #(
  parameter logic [6:0] DEV_ADDR    = 7'h19,
  parameter int         REG_AW      = 6,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  i2c_sensor_responder_if.slave io_bus
);
  localparam int NREGS = 2 ** REG_AW;

  typedef enum logic [3:0] {
    S_IDLE, S_DEV_ADDR, S_DEV_ACK, S_SUB_ADDR, S_SUB_ACK,
    S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK, S_WAIT
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
  logic                   r_scl_d, r_sda_d;
  logic                   w_scl, w_sda, w_scl_rise, w_scl_fall, w_start, w_stop, w_bus_evt;
  logic [7:0]             r_shift;
  logic [3:0]             r_bitcnt;
  logic [REG_AW-1:0]      r_ptr, w_step;
  logic                   r_mack;
  logic                   r_sda_oe, w_sda_oe_nxt, r_busy, w_busy_nxt;
  logic                   r_wr_stb;
  logic [REG_AW-1:0]      r_wr_addr;
  logic [7:0]             r_wr_data;
  logic [7:0]             r_regs [NREGS];
  logic                   w_byte_done, w_addr_hit, w_commit, w_load, w_adv;
  logic [7:0]             w_wr_byte, w_rd_byte;
`ifdef I2C_RESP_AUTOINC_EN
  logic                   r_autoinc;
  assign w_adv = r_autoinc;
`else
  assign w_adv = 1'b1;
`endif

  // Synchronisers reset to the idle-bus level so reset release never fakes an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], io_bus.scl_i};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], io_bus.sda_i};
      r_scl_d    <= w_scl;
      r_sda_d    <= w_sda;
    end
  end

  assign w_scl       = r_scl_sync[SYNC_STAGES-1];
  assign w_sda       = r_sda_sync[SYNC_STAGES-1];
  assign w_scl_rise  = w_scl & ~r_scl_d;
  assign w_scl_fall  = ~w_scl & r_scl_d;
  assign w_start     = w_scl & r_scl_d & r_sda_d & ~w_sda;
  assign w_stop      = w_scl & r_scl_d & ~r_sda_d & w_sda;
  assign w_bus_evt   = w_start | w_stop;
  assign w_byte_done = (r_bitcnt == 4'd8);
  assign w_addr_hit  = (r_shift[7:1] == DEV_ADDR);
  assign w_wr_byte   = {r_shift[6:0], w_sda};
  assign w_rd_byte   = r_regs[r_ptr];
  assign w_step      = {{(REG_AW-1){1'b0}}, w_adv};
  assign w_commit    = ~w_bus_evt & w_scl_rise & (r_state == S_WR_DATA) & (r_bitcnt == 4'd7);
  // R/W bit stays in r_shift[0] through DEV_ACK because nothing shifts in that state.
  assign w_load      = ~w_bus_evt & w_scl_fall &
                       (((r_state == S_DEV_ACK) & r_shift[0]) | ((r_state == S_RD_ACK) & ~r_mack));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_sda_oe <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_sda_oe <= w_sda_oe_nxt;
      r_busy   <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_sda_oe_nxt = r_sda_oe;
    w_busy_nxt   = r_busy;
    if (w_bus_evt) begin
      w_state_nxt  = w_start ? S_DEV_ADDR : S_IDLE;
      w_sda_oe_nxt = 1'b0;
      w_busy_nxt   = 1'b0;
    end else if (w_scl_fall) begin
      case (r_state)
        S_DEV_ADDR: if (w_byte_done) begin
          if (w_addr_hit) begin
            w_state_nxt  = S_DEV_ACK;
            w_sda_oe_nxt = 1'b1;
            w_busy_nxt   = 1'b1;
          end else begin
            w_state_nxt  = S_IDLE;
          end
        end
        S_DEV_ACK: begin
          w_state_nxt  = r_shift[0] ? S_RD_DATA : S_SUB_ADDR;
          w_sda_oe_nxt = r_shift[0] & ~w_rd_byte[7];
        end
        S_SUB_ADDR: if (w_byte_done) begin
          w_state_nxt  = S_SUB_ACK;
          w_sda_oe_nxt = 1'b1;
        end
        S_SUB_ACK, S_WR_ACK: begin
          w_state_nxt  = S_WR_DATA;
          w_sda_oe_nxt = 1'b0;
        end
        S_WR_DATA: if (w_byte_done) begin
          w_state_nxt  = S_WR_ACK;
          w_sda_oe_nxt = 1'b1;
        end
        S_RD_DATA: begin
          if (w_byte_done) begin
            w_state_nxt  = S_RD_ACK;
            w_sda_oe_nxt = 1'b0;
          end else begin
            w_sda_oe_nxt = ~r_shift[6];
          end
        end
        S_RD_ACK: begin
          w_state_nxt  = r_mack ? S_WAIT : S_RD_DATA;
          w_sda_oe_nxt = ~r_mack & ~w_rd_byte[7];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift   <= 8'h00;
      r_bitcnt  <= 4'd0;
      r_ptr     <= '0;
      r_mack    <= 1'b1;
      r_wr_stb  <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= 8'h00;
`ifdef I2C_RESP_AUTOINC_EN
      r_autoinc <= 1'b0;
`endif
    end else begin
      r_wr_stb <= w_commit;
      if (w_commit) begin
        r_wr_addr <= r_ptr;
        r_wr_data <= w_wr_byte;
      end
      if (w_start) begin
        r_bitcnt <= 4'd0;
      end else if (!w_stop && w_scl_rise) begin
        case (r_state)
          S_DEV_ADDR, S_SUB_ADDR, S_WR_DATA: begin
            r_shift  <= w_wr_byte;
            r_bitcnt <= r_bitcnt + 4'd1;
          end
          S_RD_DATA: r_bitcnt <= r_bitcnt + 4'd1;
          S_RD_ACK:  r_mack   <= w_sda;
          default: ;
        endcase
        if (w_commit) r_ptr <= r_ptr + w_step;
      end else if (!w_stop && w_scl_fall) begin
        case (r_state)
          S_SUB_ADDR: if (w_byte_done) begin
            r_ptr <= r_shift[REG_AW-1:0];
`ifdef I2C_RESP_AUTOINC_EN
            r_autoinc <= r_shift[7];
`endif
          end
          S_RD_DATA: if (!w_byte_done) r_shift <= {r_shift[6:0], 1'b0};
          S_DEV_ACK, S_SUB_ACK, S_WR_ACK, S_RD_ACK: r_bitcnt <= 4'd0;
          default: ;
        endcase
        if (w_load) begin
          r_shift <= w_rd_byte;
          r_ptr   <= r_ptr + w_step;
        end
      end
    end
  end

  // An I2C commit to the same entry takes priority over a simultaneous host write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= 8'h00;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (w_commit && r_ptr == REG_AW'(i))
          r_regs[i] <= w_wr_byte;
        else if (io_bus.host_we && io_bus.host_addr == REG_AW'(i))
          r_regs[i] <= io_bus.host_data;
      end
    end
  end

  assign io_bus.sda_oe    = r_sda_oe;
  assign io_bus.busy      = r_busy;
  assign io_bus.wr_stb    = r_wr_stb;
  assign io_bus.wr_addr   = r_wr_addr;
  assign io_bus.wr_data   = r_wr_data;
  assign io_bus.dbg_state = r_state;
endmodule

// File: tb/tb_i2c_sensor_responder.sv
// Bench for i2c_sensor_responder: bit-level I2C master, register-file reference model, write/read scoreboards.
module tb_i2c_sensor_responder;
  localparam int REG_AW = 6;
  localparam int Q      = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  i2c_sensor_responder_if #(.REG_AW(REG_AW)) bus ();
  logic m_sda = 1'b1;
  assign bus.sda_i = m_sda & ~bus.sda_oe;

  i2c_sensor_responder #(.DEV_ADDR(7'h19), .REG_AW(REG_AW), .SYNC_STAGES(2)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  // Reference model: the register file as the master should see it.
  logic [7:0]  m_regs [64];
  logic [5:0]  m_ptr;
  logic        m_autoinc;
  logic [13:0] exp_wr_q [$];
  logic [7:0]  exp_rd_q [$];
  logic [7:0]  wq [$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          oe_hi_cnt = 0;
  logic        rd_valid = 1'b0;
  logic [7:0]  rd_obs = 8'h00;
  logic [13:0] mon_wr_e;
  logic [7:0]  mon_rd_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_regs[i] = 8'h00;
    m_ptr     = 6'd0;
    m_autoinc = 1'b0;
  endtask

  task automatic model_step();
`ifdef I2C_RESP_AUTOINC_EN
    if (m_autoinc) m_ptr = m_ptr + 6'd1;
`else
    m_ptr = m_ptr + 6'd1;
`endif
  endtask

  // Scoreboard monitors
  always @(negedge clk) begin
    if (rst_n && bus.wr_stb) begin
      if (exp_wr_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL wr_unexpected: got addr 0x%0h data 0x%0h expected no commit", bus.wr_addr, bus.wr_data);
      end else begin
        mon_wr_e = exp_wr_q.pop_front();
        check("wr_commit", {18'd0, bus.wr_addr, bus.wr_data}, {18'd0, mon_wr_e});
      end
    end
    if (rd_valid) begin
      if (exp_rd_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL rd_unexpected: got 0x%0h expected nothing", rd_obs);
      end else begin
        mon_rd_e = exp_rd_q.pop_front();
        check("rd_data", {24'd0, rd_obs}, {24'd0, mon_rd_e});
      end
    end
  end

  always @(posedge clk) if (bus.sda_oe) oe_hi_cnt++;

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Drivers
  task automatic wait_q();
    repeat (Q) @(posedge clk);
    #1;
  endtask

  task automatic bit_xfer(input logic b, output logic s, input logic poke,
                          input logic [5:0] pa, input logic [7:0] pd);
    m_sda = b;
    wait_q();
    bus.scl_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    if (poke) begin
      bus.host_we   = 1'b1;
      bus.host_addr = pa;
      bus.host_data = pd;
    end
    @(posedge clk);
    #1;
    bus.host_we = 1'b0;
    s = bus.sda_i;
    repeat (2) @(posedge clk);
    #1;
    bus.scl_i = 1'b0;
    wait_q();
  endtask

  task automatic i2c_start();
    m_sda = 1'b1;
    wait_q();
    bus.scl_i = 1'b1;
    wait_q();
    m_sda = 1'b0;
    wait_q();
    bus.scl_i = 1'b0;
    wait_q();
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0;
    wait_q();
    bus.scl_i = 1'b1;
    wait_q();
    m_sda = 1'b1;
    wait_q();
    wait_q();
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack, input logic poke,
                           input logic [5:0] pa, input logic [7:0] pd);
    logic s;
    for (int i = 7; i >= 0; i--) bit_xfer(b[i], s, poke && (i == 0), pa, pd);
    bit_xfer(1'b1, s, 1'b0, 6'd0, 8'd0);
    ack = ~s;
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, s, 1'b0, 6'd0, 8'd0);
      b[i] = s;
    end
    bit_xfer(nack, s, 1'b0, 6'd0, 8'd0);
    rd_obs   = b;
    rd_valid = 1'b1;
    @(posedge clk);
    #1;
    rd_valid = 1'b0;
  endtask

  task automatic host_write(input logic [5:0] a, input logic [7:0] d);
    @(posedge clk);
    #1;
    bus.host_we   = 1'b1;
    bus.host_addr = a;
    bus.host_data = d;
    @(posedge clk);
    #1;
    bus.host_we = 1'b0;
    m_regs[a]   = d;
  endtask

  task automatic i2c_write(input logic [7:0] sub, input logic [7:0] data [$], input logic poke_last,
                           input logic [5:0] pa, input logic [7:0] pd);
    logic ack;
    logic pk;
    i2c_start();
    send_byte(8'h32, ack, 1'b0, 6'd0, 8'd0);
    check("dev_ack_w", {31'd0, ack}, 32'd1);
    check("busy_in_xfer", {31'd0, bus.busy}, 32'd1);
    send_byte(sub, ack, 1'b0, 6'd0, 8'd0);
    check("sub_ack", {31'd0, ack}, 32'd1);
    m_ptr     = sub[5:0];
    m_autoinc = sub[7];
    foreach (data[i]) begin
      pk = poke_last && (i == data.size() - 1);
      exp_wr_q.push_back({m_ptr, data[i]});
      if (pk && pa != m_ptr) m_regs[pa] = pd;
      m_regs[m_ptr] = data[i];
      model_step();
      send_byte(data[i], ack, pk, pa, pd);
      check("wr_ack", {31'd0, ack}, 32'd1);
    end
    i2c_stop();
    check("busy_after_stop", {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic i2c_read(input logic use_sub, input logic [7:0] sub, input int n);
    logic       ack;
    logic [7:0] b;
    i2c_start();
    if (use_sub) begin
      send_byte(8'h32, ack, 1'b0, 6'd0, 8'd0);
      check("dev_ack_w", {31'd0, ack}, 32'd1);
      send_byte(sub, ack, 1'b0, 6'd0, 8'd0);
      check("sub_ack", {31'd0, ack}, 32'd1);
      m_ptr     = sub[5:0];
      m_autoinc = sub[7];
      i2c_start();
    end
    send_byte(8'h33, ack, 1'b0, 6'd0, 8'd0);
    check("dev_ack_r", {31'd0, ack}, 32'd1);
    for (int i = 0; i < n; i++) begin
      exp_rd_q.push_back(m_regs[m_ptr]);
      model_step();
      recv_byte(i == n - 1, b);
    end
    check("sda_released_after_nack", {31'd0, bus.sda_oe}, 32'd0);
    i2c_stop();
    check("busy_after_stop", {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    logic       s, ack;
    logic [7:0] r_sub, r_dat;
    logic [5:0] r_adr;
    int         rn;
    model_reset();
    bus.scl_i     = 1'b1;
    bus.host_we   = 1'b0;
    bus.host_addr = '0;
    bus.host_data = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sda_oe", {31'd0, bus.sda_oe}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_wr_stb", {31'd0, bus.wr_stb}, 32'd0);
    check("rst_wr_addr", {26'd0, bus.wr_addr}, 32'd0);
    check("rst_wr_data", {24'd0, bus.wr_data}, 32'd0);
    check("rst_state", {28'd0, bus.dbg_state}, 32'd0);
    rst_n = 1'b1;
    wait_q();

    // Single register write, then read back
    wq.delete();
    wq.push_back(8'h37);
    i2c_write(8'h20, wq, 1'b0, 6'd0, 8'd0);
    i2c_read(1'b1, 8'hA0, 1);

    // Preloaded burst read with and without sub-address bit 7
    host_write(6'h28, 8'h34);
    host_write(6'h29, 8'h12);
    i2c_read(1'b1, 8'hA8, 2);
    i2c_read(1'b1, 8'h28, 2);

    // Foreign address: never acknowledged, nothing committed
    oe_hi_cnt = 0;
    i2c_start();
    send_byte(8'h3C, ack, 1'b0, 6'd0, 8'd0);
    check("foreign_nack", {31'd0, ack}, 32'd0);
    check("foreign_busy", {31'd0, bus.busy}, 32'd0);
    send_byte(8'h20, ack, 1'b0, 6'd0, 8'd0);
    send_byte(8'h37, ack, 1'b0, 6'd0, 8'd0);
    i2c_stop();
    check("foreign_sda_untouched", oe_hi_cnt, 32'd0);

    // Host write colliding with an I2C commit (same and different entry)
    wq.delete();
    wq.push_back(8'h55);
    i2c_write(8'h20, wq, 1'b1, 6'h20, 8'hAA);
    i2c_read(1'b1, 8'hA0, 1);
    wq.delete();
    wq.push_back(8'h66);
    i2c_write(8'h21, wq, 1'b1, 6'h05, 8'h77);
    i2c_read(1'b1, 8'h85, 1);
    i2c_read(1'b1, 8'hA1, 1);

    // Pointer wrap at the top of the register file
    wq.delete();
    wq.push_back(8'h11);
    wq.push_back(8'h22);
    i2c_write(8'hBF, wq, 1'b0, 6'd0, 8'd0);
    i2c_read(1'b1, 8'hBF, 2);

    // Reset during bit 4 of a read byte (0xA5 puts a 0 on that bit)
    host_write(6'h28, 8'hA5);
    i2c_start();
    send_byte(8'h32, ack, 1'b0, 6'd0, 8'd0);
    send_byte(8'hA8, ack, 1'b0, 6'd0, 8'd0);
    i2c_start();
    send_byte(8'h33, ack, 1'b0, 6'd0, 8'd0);
    for (int i = 0; i < 3; i++) bit_xfer(1'b1, s, 1'b0, 6'd0, 8'd0);
    m_sda = 1'b1;
    wait_q();
    bus.scl_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("oe_before_reset", {31'd0, bus.sda_oe}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("oe_after_reset", {31'd0, bus.sda_oe}, 32'd0);
    check("busy_after_reset", {31'd0, bus.busy}, 32'd0);
    check("state_after_reset", {28'd0, bus.dbg_state}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    bus.scl_i = 1'b0;
    wait_q();
    i2c_stop();
    i2c_read(1'b1, 8'hA8, 2);
    wq.delete();
    wq.push_back(8'h37);
    i2c_write(8'h20, wq, 1'b0, 6'd0, 8'd0);
    i2c_read(1'b1, 8'hA0, 1);

    // Randomised traffic against the model
    for (int it = 0; it < 25; it++) begin
      r_sub = 8'($urandom_range(0, 255));
      r_dat = 8'($urandom_range(0, 255));
      r_adr = 6'($urandom_range(0, 63));
      case ($urandom_range(0, 3))
        0: host_write(r_adr, r_dat);
        1: begin
          wq.delete();
          rn = $urandom_range(1, 4);
          for (int j = 0; j < rn; j++) wq.push_back(8'($urandom_range(0, 255)));
          i2c_write(r_sub, wq, 1'($urandom_range(0, 1)), r_adr, r_dat);
        end
        2: i2c_read(1'b1, r_sub, $urandom_range(1, 4));
        default: i2c_read(1'b0, 8'h00, $urandom_range(1, 3));
      endcase
    end

    repeat (4) @(posedge clk);
    #1;
    check("wr_queue_drained", exp_wr_q.size(), 32'd0);
    check("rd_queue_drained", exp_rd_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
